uart_rx_axil_poller: RTL and testbench

Parametrised AXI4-Lite master that polls a UART-Lite-style peripheral and drains received characters into a local FIFO. It presents them downstream as a ready/valid byte stream. The block sits between the ESP32 UART peripheral and the RX control logic. It adds continuous polling with back-off, buffering, response-error handling and sticky line-error capture.

---
 rtl/uart_rx_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 82 ++++++++
 rtl/uart_rx_axil_poller.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_axil_poller.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART-Lite RX poller.
//   - state_e       : poller FSM states
//   - RESP_*        : AXI read response encodings
//   - STAT_*        : bit positions inside the peripheral status register
//   - DEF_*_ADDR    : default register offsets of the peripheral
//   - line_errors() : extracts {parity, frame, overrun} from a status byte
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STAT_AR,
        STAT_R,
        DATA_AR,
        DATA_R,
        BACKOFF
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned STAT_RX_VALID = 0;
    localparam int unsigned STAT_OVERRUN  = 5;
    localparam int unsigned STAT_FRAME    = 6;
    localparam int unsigned STAT_PARITY   = 7;

    localparam int unsigned DEF_RX_ADDR   = 'h0;
    localparam int unsigned DEF_STAT_ADDR = 'h8;

    // Line-error bits in the order they are reported on err_flags.
    function automatic logic [2:0] line_errors(input logic [7:0] status);
        return {status[STAT_PARITY], status[STAT_FRAME], status[STAT_OVERRUN]};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   push/din   : write din when push is high and there is room
//   pop        : drop the head entry; ignored while empty
//   dout       : current head entry (zero while empty)
//   empty/full : occupancy flags
//   level      : number of stored entries, 0..DEPTH
// Push and pop may occur in the same cycle; on an empty FIFO only the push
// takes effect. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;

    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Masking keeps dout at zero while nothing valid is stored.
    assign dout = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: the storage array has no reset; every entry is written before
    // it can be read, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_rx_axil_poller.sv
// AXI4-Lite read master that polls a UART-Lite style peripheral and drains
// received characters into a local FIFO presented as a ready/valid stream.
//   enable                 : polling allowed while high (sampled in IDLE only)
//   m_data/m_valid/m_ready : downstream character stream (FIFO head)
//   fifo_level             : FIFO occupancy
//   err_flags              : sticky {parity, frame, overrun} from status reads
//   resp_err               : sticky, set by any non-OKAY read response
//   err_clr                : clears err_flags and resp_err
//   araddr/arvalid/arready : AXI read address channel
//   rdata/rresp/rvalid/rready : AXI read data channel
// A poll reads the status register; if a character is waiting it then reads
// the RX register. Empty status or an error response waits POLL_GAP cycles
// before the next poll.
module uart_rx_axil_poller
    import uart_rx_pkg::*;
#(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned CHAR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RX_ADDR    = DEF_RX_ADDR,
    parameter int unsigned STAT_ADDR  = DEF_STAT_ADDR,
    parameter int unsigned POLL_GAP   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    output logic [CHAR_W-1:0]           m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [2:0]                  err_flags,
    output logic                        resp_err,
    input  logic                        err_clr,
    output logic [ADDR_W-1:0]           araddr,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [AXI_DATA_W-1:0]       rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rvalid,
    output logic                        rready
);

    localparam int unsigned CNT_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(POLL_GAP - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bo_cnt_q, bo_cnt_d;
    logic [2:0]       err_flags_q, err_flags_d;
    logic             resp_err_q, resp_err_d;
    logic             fifo_push;
    logic             fifo_empty;
    logic             fifo_full;
    logic             resp_ok;

    // Only the character and status bits are consumed; the rest of the
    // read word is intentionally ignored.
    logic unused_rdata;
    assign unused_rdata = ^rdata;

    assign resp_ok = (rresp == RESP_OKAY);

    sync_fifo #(
        .WIDTH (CHAR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (m_ready),
        .din   (rdata[CHAR_W-1:0]),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign m_valid   = ~fifo_empty;
    assign err_flags = err_flags_q;
    assign resp_err  = resp_err_q;

    // Next-state logic. err_clr is applied first so an error captured in
    // the same cycle is OR-ed on top and survives the clear.
    always_comb begin
        // NOTE: every signal written here gets a default before the case, so
        // no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        bo_cnt_d    = bo_cnt_q;
        err_flags_d = err_clr ? 3'b000 : err_flags_q;
        resp_err_d  = err_clr ? 1'b0 : resp_err_q;
        fifo_push   = 1'b0;

        case (state_q)
            IDLE: begin
                // Space is checked before polling, so a data read always
                // has a free FIFO slot waiting for it.
                if (enable && !fifo_full) begin
                    state_d = STAT_AR;
                end
            end
            STAT_AR: begin
                if (arready) begin
                    state_d = STAT_R;
                end
            end
            STAT_R: begin
                if (rvalid) begin
                    if (!resp_ok) begin
                        resp_err_d = 1'b1;
                        state_d    = BACKOFF;
                        bo_cnt_d   = GAP_LOAD;
                    end else begin
                        err_flags_d = err_flags_d | line_errors(rdata[7:0]);
                        if (rdata[STAT_RX_VALID]) begin
                            state_d = DATA_AR;
                        end else begin
                            state_d  = BACKOFF;
                            bo_cnt_d = GAP_LOAD;
                        end
                    end
                end
            end
            DATA_AR: begin
                if (arready) begin
                    state_d = DATA_R;
                end
            end
            DATA_R: begin
                if (rvalid) begin
                    if (resp_ok) begin
                        fifo_push = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        resp_err_d = 1'b1;
                        state_d    = BACKOFF;
                        bo_cnt_d   = GAP_LOAD;
                    end
                end
            end
            BACKOFF: begin
                if (bo_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    bo_cnt_d = bo_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // AXI channel controls are pure decodes of the registered state, so
    // araddr cannot move while arvalid waits for arready.
    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        araddr  = '0;
        case (state_q)
            STAT_AR: begin
                arvalid = 1'b1;
                araddr  = ADDR_W'(STAT_ADDR);
            end
            DATA_AR: begin
                arvalid = 1'b1;
                araddr  = ADDR_W'(RX_ADDR);
            end
            STAT_R, DATA_R: begin
                rready = 1'b1;
            end
            default: begin
                arvalid = 1'b0;
            end
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop
    // samples values from before the clock edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bo_cnt_q    <= '0;
            err_flags_q <= 3'b000;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bo_cnt_q    <= bo_cnt_d;
            err_flags_q <= err_flags_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_axil_poller.sv
// Self-checking bench for uart_rx_axil_poller: a behavioural AXI4-Lite slave
// answers the polls, expected characters are queued when the slave hands out
// RX data with OKAY, and a stream monitor compares every accepted character.
module tb_uart_rx_axil_poller;
    import uart_rx_pkg::*;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned CHAR_W     = 8;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned POLL_GAP   = 16;
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] RX_A   = 4'h0;
    localparam logic [ADDR_W-1:0] STAT_A = 4'h8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  enable = 1'b0;
    logic [CHAR_W-1:0]     m_data;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [LVL_W-1:0]      fifo_level;
    logic [2:0]            err_flags;
    logic                  resp_err;
    logic                  err_clr = 1'b0;
    logic [ADDR_W-1:0]     araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    uart_rx_axil_poller #(
        .ADDR_W     (ADDR_W),
        .AXI_DATA_W (AXI_DATA_W),
        .CHAR_W     (CHAR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RX_ADDR    ('h0),
        .STAT_ADDR  ('h8),
        .POLL_GAP   (POLL_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .err_flags  (err_flags),
        .resp_err   (resp_err),
        .err_clr    (err_clr),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Slave configuration and bookkeeping.
    int unsigned      ar_delay = 0;
    int unsigned      r_delay  = 0;
    logic [31:0]      stat_val  = 32'h0;
    logic [1:0]       stat_resp = RESP_OKAY;
    logic [1:0]       data_resp = RESP_OKAY;
    logic [7:0]       rx_val    = 8'h41;
    bit               have_req, ar_pend, r_pend;
    logic [ADDR_W-1:0] req_addr, hold_addr;
    int unsigned      ar_wait, r_wait;
    int               n_stat_ar = 0, n_data_ar = 0;
    int               data_fires = 0, stat_fires = 0;
    int               last_data_fire_t = 0;
    int               stat_ar_t[$];
    logic [7:0]       exp_q[$];
    int               pops = 0;

    // Behavioural AXI4-Lite slave, evaluated on the falling edge. A handshake
    // decided here completes on the following rising edge.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
        have_req = 0; ar_pend = 0; r_pend = 0; ar_wait = 0; r_wait = 0;
        req_addr = '0; hold_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 1'b0; rvalid = 1'b0;
                have_req = 0; ar_pend = 0; r_pend = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (r_pend) begin rvalid = 1'b0; r_pend = 0; end
                if (ar_pend) begin arready = 1'b0; ar_pend = 0; have_req = 1; r_wait = 0; end
                if (!have_req && !ar_pend) begin
                    if (ar_wait > 0) begin
                        checks++;
                        if (arvalid !== 1'b1 || araddr !== hold_addr) begin
                            failures++;
                            $display("FAIL ar_stable: arvalid=%b araddr=%h, required arvalid=1 araddr=%h", arvalid, araddr, hold_addr);
                        end
                    end
                    if (arvalid !== 1'b1) begin
                        ar_wait = 0;
                    end else begin
                        if (ar_wait == 0) hold_addr = araddr;
                        if (ar_wait < ar_delay) begin
                            ar_wait++;
                        end else begin
                            arready = 1'b1; ar_pend = 1; req_addr = araddr; ar_wait = 0;
                            if (araddr == STAT_A) begin n_stat_ar++; stat_ar_t.push_back(cyc + 1); end
                            else n_data_ar++;
                        end
                    end
                end
                if (have_req && !rvalid) begin
                    if (r_wait < r_delay) begin
                        r_wait++;
                    end else begin
                        rvalid = 1'b1;
                        if (req_addr == STAT_A) begin rdata = stat_val; rresp = stat_resp; end
                        else begin rdata = {24'h0, rx_val}; rresp = data_resp; end
                    end
                end
                if (rvalid && rready && !r_pend) begin
                    r_pend = 1; have_req = 0;
                    if (req_addr == RX_A) begin
                        data_fires++;
                        last_data_fire_t = cyc + 1;
                        if (rresp == RESP_OKAY) exp_q.push_back(rx_val);
                        rx_val = rx_val + 8'd1;
                    end else begin
                        stat_fires++;
                    end
                end
            end
        end
    end

    // Stream monitor: every accepted character must match the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                checks++;
                pops++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_unexpected: got char %h, required none", m_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        failures++;
                        $display("FAIL stream_data: got %h, required %h", m_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_data_fires(input int target, input int budget, input string name);
        int i;
        for (i = 0; i < budget && data_fires < target; i++) tick();
        if (data_fires < target) begin
            checks++; failures++;
            $display("FAIL %s_timeout: data reads=%0d, required %0d", name, data_fires, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        tick(3);
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid: got %b, required 0", arvalid); end
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready: got %b, required 0", rready); end
        checks++; if (araddr !== '0) begin failures++; $display("FAIL reset_araddr: got %h, required 0", araddr); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data: got %h, required 0", m_data); end
        checks++; if (fifo_level !== '0) begin failures++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
        checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL reset_err_flags: got %b, required 000", err_flags); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err: got %b, required 0", resp_err); end
        rst = 1'b0;
        tick(5);
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL idle_disabled: arvalid=%b, required 0", arvalid); end
    endtask

    task automatic test_stream();
        int start, p0, found;
        logic mv_prev;
        stat_val = 32'h01; stat_resp = RESP_OKAY; data_resp = RESP_OKAY; rx_val = 8'h41;
        m_ready = 1'b1; stat_ar_t.delete(); start = data_fires; p0 = pops;
        enable = 1'b1;
        found = 0; mv_prev = 1'b0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            mv_prev = m_valid;
            tick();
            if (data_fires != start) found = 1;
        end
        if (found == 0) begin
            checks++; failures++;
            $display("FAIL stream_first_timeout: no data read seen");
        end else begin
            checks++; if (mv_prev !== 1'b0) begin failures++; $display("FAIL stream_early_valid: m_valid=%b before data beat, required 0", mv_prev); end
            checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL stream_latency: m_valid=%b one cycle after data beat, required 1", m_valid); end
            checks++; if (m_data !== 8'h41) begin failures++; $display("FAIL stream_first_char: got %h, required 41", m_data); end
        end
        wait_data_fires(start + 7, 200, "stream");
        enable = 1'b0;
        tick(30);
        for (int i = 1; i < stat_ar_t.size(); i++) begin
            checks++;
            if (stat_ar_t[i] - stat_ar_t[i-1] != 5) begin
                failures++;
                $display("FAIL stream_period: got %0d cycles, required 5", stat_ar_t[i] - stat_ar_t[i-1]);
            end
        end
        checks++; if (pops - p0 != 7) begin failures++; $display("FAIL stream_count: got %0d chars, required 7", pops - p0); end
    endtask

    task automatic test_empty_poll();
        int d0;
        stat_val = 32'h00; stat_ar_t.delete(); d0 = n_data_ar;
        enable = 1'b1;
        tick(19 * 6 + 5);
        enable = 1'b0;
        tick(POLL_GAP + 10);
        checks++; if (stat_ar_t.size() < 5) begin failures++; $display("FAIL empty_poll_count: got %0d polls, required at least 5", stat_ar_t.size()); end
        for (int i = 1; i < stat_ar_t.size(); i++) begin
            checks++;
            if (stat_ar_t[i] - stat_ar_t[i-1] != 3 + POLL_GAP) begin
                failures++;
                $display("FAIL empty_poll_period: got %0d cycles, required %0d", stat_ar_t[i] - stat_ar_t[i-1], 3 + POLL_GAP);
            end
        end
        checks++; if (n_data_ar != d0) begin failures++; $display("FAIL empty_poll_rx_read: got %0d RX reads, required 0", n_data_ar - d0); end
    endtask

    task automatic test_fill();
        int d0, ar0, p0, i;
        stat_val = 32'h01; m_ready = 1'b0;
        d0 = n_data_ar; ar0 = n_stat_ar + n_data_ar; p0 = pops;
        enable = 1'b1;
        for (i = 0; i < 300 && fifo_level != LVL_W'(FIFO_DEPTH); i++) tick();
        tick(40);
        checks++; if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin failures++; $display("FAIL fill_level: got %0d, required %0d", fifo_level, FIFO_DEPTH); end
        checks++; if (n_data_ar - d0 != FIFO_DEPTH) begin failures++; $display("FAIL fill_reads: got %0d, required %0d", n_data_ar - d0, FIFO_DEPTH); end
        checks++; if (n_stat_ar + n_data_ar - ar0 != 2 * FIFO_DEPTH) begin failures++; $display("FAIL fill_no_extra_ar: got %0d AR, required %0d", n_stat_ar + n_data_ar - ar0, 2 * FIFO_DEPTH); end
        checks++; if (exp_q.size() != FIFO_DEPTH) begin failures++; $display("FAIL fill_scoreboard: got %0d pending, required %0d", exp_q.size(), FIFO_DEPTH); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick(40);
        checks++; if (pops - p0 != 1) begin failures++; $display("FAIL fill_single_pop: got %0d pops, required 1", pops - p0); end
        checks++; if (n_data_ar - d0 != FIFO_DEPTH + 1) begin failures++; $display("FAIL fill_refill: got %0d reads, required %0d", n_data_ar - d0, FIFO_DEPTH + 1); end
        checks++; if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin failures++; $display("FAIL fill_level_after: got %0d, required %0d", fifo_level, FIFO_DEPTH); end
        enable = 1'b0;
        tick(5);
        m_ready = 1'b1;
        for (i = 0; i < 50 && m_valid; i++) tick();
        tick(2);
        checks++; if (m_valid !== 1'b0 || fifo_level !== '0) begin failures++; $display("FAIL fill_drain: m_valid=%b level=%0d, required 0 and 0", m_valid, fifo_level); end
        checks++; if (pops - p0 != FIFO_DEPTH + 1) begin failures++; $display("FAIL fill_drain_count: got %0d, required %0d", pops - p0, FIFO_DEPTH + 1); end
    endtask

    task automatic test_errors();
        int start, p0, d0, fire_t, found;
        m_ready = 1'b1;
        // Status with all line-error bits plus a waiting character.
        stat_val = 32'hE1; start = data_fires; p0 = pops;
        enable = 1'b1;
        wait_data_fires(start + 1, 100, "err_flags");
        enable = 1'b0;
        tick(20);
        checks++; if (err_flags !== 3'b111) begin failures++; $display("FAIL err_flags_set: got %b, required 111", err_flags); end
        checks++; if (pops - p0 != 1) begin failures++; $display("FAIL err_char_pushed: got %0d chars, required 1", pops - p0); end
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        checks++; if (err_flags !== 3'b000) begin failures++; $display("FAIL err_clr: got %b, required 000", err_flags); end
        // Overrun only, then parity+frame: flags accumulate.
        stat_val = 32'h21; start = data_fires;
        enable = 1'b1; wait_data_fires(start + 1, 100, "err_overrun"); enable = 1'b0; tick(20);
        checks++; if (err_flags !== 3'b001) begin failures++; $display("FAIL err_overrun: got %b, required 001", err_flags); end
        stat_val = 32'hC1; start = data_fires;
        enable = 1'b1; wait_data_fires(start + 1, 100, "err_sticky"); enable = 1'b0; tick(20);
        checks++; if (err_flags !== 3'b111) begin failures++; $display("FAIL err_sticky: got %b, required 111", err_flags); end
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        // SLVERR on the data read while err_clr is held: the error must win.
        stat_val = 32'h01; data_resp = RESP_SLVERR; p0 = pops; stat_ar_t.delete();
        err_clr = 1'b1; start = data_fires;
        enable = 1'b1;
        wait_data_fires(start + 1, 100, "slverr");
        err_clr = 1'b0;
        fire_t = last_data_fire_t;
        checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL resp_err_wins: got %b, required 1", resp_err); end
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            tick();
            if (stat_ar_t.size() > 0 && stat_ar_t[$] > fire_t) found = 1;
        end
        enable = 1'b0;
        checks++;
        if (found == 0) begin
            failures++; $display("FAIL slverr_backoff_timeout: no poll after error");
        end else if (stat_ar_t[$] - fire_t != POLL_GAP + 2) begin
            failures++; $display("FAIL slverr_backoff: next poll after %0d cycles, required %0d", stat_ar_t[$] - fire_t, POLL_GAP + 2);
        end
        tick(POLL_GAP + 40);
        checks++; if (pops != p0 || m_valid !== 1'b0) begin failures++; $display("FAIL slverr_no_push: pops=%0d m_valid=%b, required %0d and 0", pops, m_valid, p0); end
        data_resp = RESP_OKAY;
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL resp_err_clr: got %b, required 0", resp_err); end
        // DECERR on the status read: no data read, status bits ignored.
        stat_val = 32'hE1; stat_resp = RESP_DECERR; d0 = n_data_ar; start = stat_fires;
        enable = 1'b1;
        for (int i = 0; i < 60 && stat_fires == start; i++) tick();
        enable = 1'b0;
        tick(POLL_GAP + 10);
        checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL stat_decerr: resp_err=%b, required 1", resp_err); end
        checks++; if (n_data_ar != d0 || err_flags !== 3'b000) begin failures++; $display("FAIL stat_decerr_effects: rx reads=%0d flags=%b, required 0 and 000", n_data_ar - d0, err_flags); end
        stat_resp = RESP_OKAY;
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    endtask

    task automatic test_delay_reset();
        int found, p0, start;
        ar_delay = 3; r_delay = 2; stat_val = 32'h01; m_ready = 1'b0;
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (fifo_level >= 1 && rready && have_req && req_addr == RX_A) found = 1;
        end
        checks++;
        if (found == 0) begin
            failures++; $display("FAIL delay_reach_data_r: second data read not reached");
        end
        rst = 1'b1; enable = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin failures++; $display("FAIL midreset_axi: arvalid=%b rready=%b, required 0 0", arvalid, rready); end
        checks++; if (fifo_level !== '0 || m_valid !== 1'b0) begin failures++; $display("FAIL midreset_fifo: level=%0d m_valid=%b, required 0 0", fifo_level, m_valid); end
        tick(2);
        rst = 1'b0;
        tick(10);
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin failures++; $display("FAIL midreset_idle: arvalid=%b rready=%b, required 0 0", arvalid, rready); end
        // Recovery: a fresh character flows through after reset.
        ar_delay = 0; r_delay = 0; m_ready = 1'b1; p0 = pops; start = data_fires;
        enable = 1'b1;
        wait_data_fires(start + 1, 100, "recover");
        enable = 1'b0;
        tick(20);
        checks++; if (pops - p0 != 1) begin failures++; $display("FAIL recover_char: got %0d chars, required 1", pops - p0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_empty_poll();
        test_fill();
        test_errors();
        test_delay_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d characters never delivered, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
